// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared forwarding-select and hazard-state encodings for the 5-stage pipeline.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    FWD_REG    = 2'b00,
    FWD_MEM_WB = 2'b01,
    FWD_EX_MEM = 2'b10
  } fwd_sel_e;
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } hz_state_e;
endpackage

// File: rtl/fwd_sel_calc.sv
// fwd_sel_calc: per-operand forwarding select from ID source compare against ID/EX and EX/MEM.
module fwd_sel_calc
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_rs,
  input  logic              i_uses,
  input  logic [REG_AW-1:0] i_id_ex_rd,
  input  logic              i_id_ex_reg_write,
  input  logic [REG_AW-1:0] i_ex_mem_rd,
  input  logic              i_ex_mem_reg_write,
  output fwd_sel_e          o_sel
);
  logic w_live;
  assign w_live = i_uses && (i_rs != '0);
  // the younger producer (now in ID/EX, next in EX/MEM) holds the newest value
  assign o_sel = (w_live && i_id_ex_reg_write && i_id_ex_rd == i_rs)   ? FWD_EX_MEM :
                 (w_live && i_ex_mem_reg_write && i_ex_mem_rd == i_rs) ? FWD_MEM_WB : FWD_REG;
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: forwarding selects, load-use stall, branch flush and dmem-wait freeze.
module hazard_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_uses_rs1,
  input  logic              i_id_uses_rs2,
  input  logic [REG_AW-1:0] i_id_ex_rd,
  input  logic              i_id_ex_reg_write,
  input  logic              i_id_ex_mem_read,
  input  logic [REG_AW-1:0] i_ex_mem_rd,
  input  logic              i_ex_mem_reg_write,
  input  logic              i_ex_mem_mem_access,
  input  logic              i_dmem_ready,
  input  logic              i_ex_branch_taken,
  output logic              o_pc_write,
  output logic              o_if_id_write,
  output logic              o_if_id_flush,
  output logic              o_id_ex_bubble,
  output logic              o_pipe_freeze,
  output logic [1:0]        o_forward_a,
  output logic [1:0]        o_forward_b,
  output logic [CNT_W-1:0]  o_stall_cycles,
  output hz_state_e         o_state
);
  fwd_sel_e   w_sel_a, w_sel_b, r_fwd_a, r_fwd_b;
  hz_state_e  r_state, w_next_state;
  logic [CNT_W-1:0] r_stall_cycles;
  logic w_mem_wait, w_flush, w_load_use, w_lu_raw;

  fwd_sel_calc #(.REG_AW(REG_AW)) u_fwd_a (
    .i_rs(i_id_rs1), .i_uses(i_id_uses_rs1),
    .i_id_ex_rd(i_id_ex_rd), .i_id_ex_reg_write(i_id_ex_reg_write),
    .i_ex_mem_rd(i_ex_mem_rd), .i_ex_mem_reg_write(i_ex_mem_reg_write),
    .o_sel(w_sel_a)
  );
  fwd_sel_calc #(.REG_AW(REG_AW)) u_fwd_b (
    .i_rs(i_id_rs2), .i_uses(i_id_uses_rs2),
    .i_id_ex_rd(i_id_ex_rd), .i_id_ex_reg_write(i_id_ex_reg_write),
    .i_ex_mem_rd(i_ex_mem_rd), .i_ex_mem_reg_write(i_ex_mem_reg_write),
    .o_sel(w_sel_b)
  );

  // rst_n gating keeps the stall/flush outputs in their run values while reset is held
  assign w_lu_raw   = i_id_ex_mem_read && (i_id_ex_rd != '0) &&
                      ((i_id_uses_rs1 && i_id_rs1 == i_id_ex_rd) || (i_id_uses_rs2 && i_id_rs2 == i_id_ex_rd));
  assign w_mem_wait = rst_n && i_ex_mem_mem_access && !i_dmem_ready;
  assign w_flush    = rst_n && !w_mem_wait && i_ex_branch_taken;
  assign w_load_use = rst_n && !w_mem_wait && !w_flush && w_lu_raw;

  always_comb begin
    w_next_state   = w_mem_wait ? MEM_WAIT : w_load_use ? LU_STALL : RUN;
    o_pc_write     = !w_mem_wait && !w_load_use;
    o_if_id_write  = !w_mem_wait && !w_load_use;
    o_if_id_flush  = w_flush;
    o_id_ex_bubble = w_flush || w_load_use;
    o_pipe_freeze  = w_mem_wait;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= RUN;
      r_fwd_a        <= FWD_REG;
      r_fwd_b        <= FWD_REG;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_next_state;
      if (!w_mem_wait) begin
        r_fwd_a <= (w_flush || w_load_use) ? FWD_REG : w_sel_a;
        r_fwd_b <= (w_flush || w_load_use) ? FWD_REG : w_sel_b;
      end
      if (w_next_state != RUN && r_stall_cycles != '1)
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign o_forward_a    = r_fwd_a;
  assign o_forward_b    = r_fwd_b;
  assign o_stall_cycles = r_stall_cycles;
  assign o_state        = r_state;
endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Pipeline hazard controller for the 5-stage RV32 core; produces the EX-stage operand forwarding selects, load-use stall/bubble, branch flush and data-memory wait freeze. Forward selects are computed in ID from source-register compares against the downstream pipeline registers and registered alongside ID/EX, so the EX forwarding muxes see a stable select from the clock edge. A small FSM tracks stall cause and a saturating counter reports stall cycles for performance monitoring.

## Interface
- REG_AW, 5, register address width
- CNT_W, 16, stall counter width
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_rs1, id_rs2  in  REG_AW  source registers of instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  operand actually read by the ID instruction
- id_ex_rd  in  REG_AW  destination register in ID/EX
- id_ex_reg_write, id_ex_mem_read  in  1  ID/EX control
- ex_mem_rd  in  REG_AW  destination register in EX/MEM
- ex_mem_reg_write  in  1  EX/MEM control
- ex_mem_mem_access  in  1  EX/MEM holds a load or store
- dmem_ready  in  1  data memory completes the access this cycle
- ex_branch_taken  in  1  redirect resolved in EX
- pc_write, if_id_write  out  1  PC and IF/ID enables
- if_id_flush, id_ex_bubble  out  1  squash IF/ID; load NOP into ID/EX
- pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
- forward_a, forward_b  out  2  registered EX forwarding selects
- stall_cycles  out  CNT_W  saturating count of non-RUN cycles

## Operation
- Select encoding: 00 register file, 01 MEM/WB result, 10 EX/MEM result; 11 never driven.
- Next-select per operand (rs, uses): if uses && rs!=0 && id_ex_reg_write && id_ex_rd==rs → 10; else if uses && rs!=0 && ex_mem_reg_write && ex_mem_rd==rs → 01; else 00. ID/EX match beats EX/MEM match.
- MEM/WB-to-ID hazards are handled by the register file's write-first read, not here.
- Conditions: mem_wait = ex_mem_mem_access && !dmem_ready; load_use = id_ex_mem_read && id_ex_rd!=0 && ((id_uses_rs1 && id_rs1==id_ex_rd) || (id_uses_rs2 && id_rs2==id_ex_rd)).
- Priority mem_wait > ex_branch_taken > load_use. A branch in EX during mem_wait is held and re-asserts next cycle.
- mem_wait: pipe_freeze=1, pc_write=0, if_id_write=0, no flush/bubble; forward regs hold.
- flush: if_id_flush=1, id_ex_bubble=1, pc_write=1; forward regs load 00.
- load_use: pc_write=0, if_id_write=0, id_ex_bubble=1; forward regs load 00 (bubble). Next cycle the load sits in EX/MEM, so the recompute yields 01.
- Otherwise: pc_write=if_id_write=1, all others 0; forward regs load next-select.
- FSM states RUN, LU_STALL, MEM_WAIT; next state = MEM_WAIT if mem_wait, else LU_STALL if load_use (and no flush), else RUN. State is informational; outputs depend only on the conditions above.
- stall_cycles increments each cycle the next state is not RUN; saturates at all-ones.

## Timing
- Reset (async assert, sync release): forward_a=forward_b=00, state RUN, stall_cycles=0. While rst_n low, combinational outputs read pc_write=if_id_write=1, others 0.
- Stall/flush/freeze outputs are combinational, valid in the same cycle as their inputs.
- forward_a/b update on the clk edge where ID/EX loads: one cycle latency from ID compare to EX use.
- Load-use costs exactly one bubble. mem_wait freezes for as many cycles as dmem_ready stays low.
- Reset mid-MEM_WAIT returns everything to reset values immediately.

## Structure
- Shared package pipe_ctrl_pkg: fwd_sel_e (FWD_REG, FWD_MEM_WB, FWD_EX_MEM), hz_state_e (RUN, LU_STALL, MEM_WAIT). These are also used by the EX forwarding muxes.
- Sub-module fwd_sel_calc: combinational per-operand compare, instantiated once for rs1 and once for rs2.

## Test plan
- ID add rs1=x5; ID/EX rd=x5, reg_write=1, mem_read=0 → no stall; next edge forward_a=10.
- ID rs2=x5; ID/EX lw rd=x5 → that cycle pc_write=0, if_id_write=0, id_ex_bubble=1; forward_b=00 after edge; next cycle compare hits EX/MEM → forward_b=01; stall_cycles=1.
- id_rs1=x0 with ID/EX rd=x0, reg_write=1 → forward_a=00, no stall.
- ex_mem_mem_access=1, dmem_ready low 3 cycles → pipe_freeze=1 for 3 cycles, forwards hold, state MEM_WAIT, stall_cycles +3.
- ex_branch_taken and load_use in the same cycle → if_id_flush=1, id_ex_bubble=1, pc_write=1, forwards 00, state RUN.
- rst_n low during MEM_WAIT with forward_a=10 → immediately forward_a=00, state RUN, stall_cycles=0.
